// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor_if
//  Description : Handshake and operand/result bundle for serial_subtractor.
//                The master side issues a request (start, a, b); the slave
//                side reports progress (busy, done) and the held result
//                (diff, borrow_out, overflow).
//  Ports       : start      - request, sampled by the slave only when idle
//                a, b       - minuend / subtrahend, N bits
//                busy       - slave is shifting bits
//                done       - one-cycle pulse, result valid
//                diff       - A - B modulo 2^N, held until the next run ends
//                borrow_out - unsigned A < B
//                overflow   - signed overflow of A - B
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic         borrow_out;
    logic         overflow;

    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  diff,
        input  borrow_out,
        input  overflow
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output diff,
        output borrow_out,
        output overflow
    );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial N-bit two's-complement subtractor, DIFF = A - B,
//                evaluated LSB-first as A + ~B + 1 through a single full-adder
//                cell with a registered carry. One result every N+2 cycles
//                when requests are issued back to back.
//  Ports       : clk    - rising-edge clock
//                reset  - synchronous, active-high
//                bus    - serial_subtractor_if.slave (start/a/b in,
//                         busy/done/diff/borrow_out/overflow out)
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int N = 8
) (
    input  wire                  clk,
    input  wire                  reset,
    serial_subtractor_if.slave   bus
);

    localparam int CW = $clog2(N);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] C_LAST_BIT = CW'(N - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]    state_q, state_d;
    logic [N-1:0]  a_sh_q, a_sh_d;
    logic [N-1:0]  b_sh_q, b_sh_d;
    // Only N-1 partial bits are ever kept: the final sum bit goes straight
    // into diff on the last edge together with these.
    logic [N-2:0]  res_q, res_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          carry_q, carry_d;
    logic [N-1:0]  diff_q, diff_d;
    logic          borrow_q, borrow_d;
    logic          ovf_q, ovf_d;

    // ------------------------------------------------------------------
    // Full-adder cell on the current LSBs: a + ~b + carry
    // ------------------------------------------------------------------
    logic         w_b_inv;
    logic         w_sum;
    logic         w_cout;
    logic         w_last;
    logic [N-1:0] w_res_full;

    assign w_b_inv    = ~b_sh_q[0];
    assign w_sum      = a_sh_q[0] ^ w_b_inv ^ carry_q;
    assign w_cout     = (a_sh_q[0] & w_b_inv) | (a_sh_q[0] & carry_q) | (w_b_inv & carry_q);
    assign w_last     = (cnt_q == C_LAST_BIT);
    // New sum bit enters at the top; after the last bit this is the full result.
    assign w_res_full = {w_sum, res_q};

    // ------------------------------------------------------------------
    // State register (also holds the datapath flops)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Always return to idle; a start seen here is dropped.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    res_d   = '0;
                    cnt_d   = '0;
                    // Carry-in of 1 supplies the "+1" of the two's complement.
                    carry_d = 1'b1;
                end
            end
            S_RUN: begin
                a_sh_d  = {1'b0, a_sh_q[N-1:1]};
                b_sh_d  = {1'b0, b_sh_q[N-1:1]};
                res_d   = w_res_full[N-1:1];
                cnt_d   = cnt_q + CW'(1);
                carry_d = w_cout;
                if (w_last) begin
                    diff_d   = w_res_full;
                    // No carry out of A + ~B + 1 means A < B unsigned.
                    borrow_d = ~w_cout;
                    // Carry into the MSB differs from carry out: signed overflow.
                    ovf_d    = carry_q ^ w_cout;
                end
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic w_busy;
    logic w_done;

    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (state_q)
            S_RUN:   w_busy = 1'b1;
            S_DONE:  w_done = 1'b1;
            default: begin
            end
        endcase
    end

    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;
    assign bus.overflow   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_subtractor
//  Description : Self-checking bench for serial_subtractor (N = 8). Expected
//                results come from plain integer arithmetic on the operands.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int N = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    serial_subtractor_if #(.N(N)) sub_if ();

    serial_subtractor #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sub_if)
    );

    int total   = 0;
    int bad     = 0;
    int accepts = 0;
    int dones   = 0;

    logic [N-1:0] last_diff;
    logic         last_borrow;
    logic         last_ovf;

    always @(negedge clk) begin
        if (sub_if.done === 1'b1) dones++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned difference modulo 2^N, borrow from unsigned compare,
    // overflow from whether the true signed difference fits in N bits.
    task automatic ref_model(input logic [N-1:0] a, input logic [N-1:0] b,
                             output logic [N-1:0] d, output logic br, output logic ov);
        int sa, sb, sd;
        sa = int'($signed(a));
        sb = int'($signed(b));
        sd = sa - sb;
        d  = N'(int'(a) - int'(b));
        br = (int'(a) < int'(b));
        ov = (sd > (2 ** (N - 1)) - 1) || (sd < -(2 ** (N - 1)));
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after
    // the DONE cycle, DUT idle again.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit hammer);
        logic [N-1:0] ed;
        logic         eb, eo;
        ref_model(a, b, ed, eb, eo);

        sub_if.start = 1'b1;
        sub_if.a     = a;
        sub_if.b     = b;
        @(posedge clk);
        accepts++;
        @(negedge clk);
        sub_if.start = 1'b0;
        sub_if.a     = N'($urandom);
        sub_if.b     = N'($urandom);

        for (int i = 0; i < N; i++) begin
            check("busy_run", 32'(sub_if.busy), 32'd1);
            check("done_run", 32'(sub_if.done), 32'd0);
            check("diff_stale", 32'(sub_if.diff), 32'(last_diff));
            check("borrow_stale", 32'(sub_if.borrow_out), 32'(last_borrow));
            check("ovf_stale", 32'(sub_if.overflow), 32'(last_ovf));
            if (hammer && i == 2) begin
                sub_if.start = 1'b1;
                sub_if.a     = 8'h10;
                sub_if.b     = 8'h01;
            end
            if (hammer && i == 3) sub_if.start = 1'b0;
            // Held high across the last RUN edge and the DONE edge.
            if (hammer && i == N - 1) begin
                sub_if.start = 1'b1;
                sub_if.a     = 8'h10;
                sub_if.b     = 8'h01;
            end
            @(negedge clk);
        end

        check("done_pulse", 32'(sub_if.done), 32'd1);
        check("busy_done", 32'(sub_if.busy), 32'd0);
        check("diff", 32'(sub_if.diff), 32'(ed));
        check("borrow_out", 32'(sub_if.borrow_out), 32'(eb));
        check("overflow", 32'(sub_if.overflow), 32'(eo));

        @(negedge clk);
        sub_if.start = 1'b0;
        check("done_fall", 32'(sub_if.done), 32'd0);
        check("busy_idle", 32'(sub_if.busy), 32'd0);
        check("diff_hold", 32'(sub_if.diff), 32'(ed));

        last_diff   = ed;
        last_borrow = eb;
        last_ovf    = eo;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"}, 32'(sub_if.busy), 32'd0);
        check({tag, "_done"}, 32'(sub_if.done), 32'd0);
        check({tag, "_diff"}, 32'(sub_if.diff), 32'd0);
        check({tag, "_borrow"}, 32'(sub_if.borrow_out), 32'd0);
        check({tag, "_ovf"}, 32'(sub_if.overflow), 32'd0);
    endtask

    initial begin
        logic [N-1:0] corners [4];
        int           dones_before;
        corners[0] = 8'h00;
        corners[1] = 8'h7F;
        corners[2] = 8'h80;
        corners[3] = 8'hFF;

        // Reset
        reset        = 1'b1;
        sub_if.start = 1'b0;
        sub_if.a     = '0;
        sub_if.b     = '0;
        last_diff    = '0;
        last_borrow  = 1'b0;
        last_ovf     = 1'b0;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        reset = 1'b0;
        @(negedge clk);
        check_cleared("post_reset");

        // Directed cases
        run_op(8'h05, 8'h03, 1'b0);
        run_op(8'h03, 8'h05, 1'b0);
        run_op(8'h00, 8'h00, 1'b0);
        run_op(8'h80, 8'h01, 1'b0);
        run_op(8'h7F, 8'hFF, 1'b0);

        // Starts during RUN and DONE are dropped; a fresh start then works
        run_op(8'h05, 8'h03, 1'b1);
        repeat (2) @(negedge clk);
        check("no_extra_run", 32'(sub_if.busy), 32'd0);
        check("no_extra_diff", 32'(sub_if.diff), 32'h02);
        run_op(8'h10, 8'h01, 1'b0);
        check("fresh_diff", 32'(sub_if.diff), 32'h0F);

        // Load nonzero outputs, then abandon a run with reset at edge k+4
        run_op(8'h7F, 8'hFF, 1'b0);
        dones_before = dones;
        sub_if.start = 1'b1;
        sub_if.a     = 8'h55;
        sub_if.b     = 8'h22;
        @(posedge clk);
        @(negedge clk);
        sub_if.start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_cleared("mid_reset");
        last_diff   = '0;
        last_borrow = 1'b0;
        last_ovf    = 1'b0;
        repeat (N + 2) @(negedge clk);
        check("mid_reset_no_done", 32'(dones), 32'(dones_before));
        check("mid_reset_idle", 32'(sub_if.busy), 32'd0);
        run_op(8'h55, 8'h22, 1'b0);

        // Reset and start together: reset wins
        reset        = 1'b1;
        sub_if.start = 1'b1;
        sub_if.a     = 8'h09;
        sub_if.b     = 8'h04;
        @(negedge clk);
        reset        = 1'b0;
        sub_if.start = 1'b0;
        check_cleared("rst_start");
        last_diff   = '0;
        last_borrow = 1'b0;
        last_ovf    = 1'b0;
        @(negedge clk);
        check("rst_start_not_run", 32'(sub_if.busy), 32'd0);

        // Random pairs
        for (int i = 0; i < 256; i++) begin
            run_op(N'($urandom), N'($urandom), 1'b0);
        end

        // Corner values squared
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                run_op(corners[i], corners[j], 1'b0);
            end
        end

        @(negedge clk);
        check("done_count", 32'(dones), 32'(accepts));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
